batch_builder: RTL and testbench

Downstream stage of the insertion block: collects single-cycle transaction strobes into batches of non-conflicting owner/program IDs for the scheduler. It drives the `pipeline_ready` / `accepted_id` feedback that insertion consumes. A batch closes on full, conflict, timeout or flush, then streams out one ID per beat over a valid/ready interface.

---
 rtl/batch_builder.sv | 159 +++++++++++++++
 tb/tb_batch_builder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/batch_builder.sv
// rtl/batch_builder.sv - collects insertion strobes into conflict-free ID batches and streams them out
module batch_builder #(
    parameter int MAX_BATCH = 8,
    parameter int ID_W      = 64,
    parameter int TIMEOUT   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             insertion_ready,
    input  logic [ID_W-1:0]                  owner_programID,
    input  logic                             flush,
    output logic                             pipeline_ready,
    output logic [ID_W-1:0]                  accepted_id,
    output logic                             accepted_valid,
    output logic                             conflict,
    output logic                             drop,
    output logic [15:0]                      drop_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ID_W-1:0]                  out_id,
    output logic                             out_last,
    output logic [$clog2(MAX_BATCH+1)-1:0]   out_size
);

    localparam int CW = $clog2(MAX_BATCH + 1);
    localparam int IW = $clog2(MAX_BATCH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    logic [ID_W-1:0] entries [MAX_BATCH];
    logic [CW-1:0]   count;
    logic [TW-1:0]   timer;
    logic [IW-1:0]   rd_idx;
    logic [ID_W-1:0] carry_id;
    logic            carry_valid;

    logic            accept_ok;
    logic            is_dup;
    logic            do_write;
    logic            do_park;
    logic [CW-1:0]   count_post;
    logic            timed_out;
    logic            close_batch;
    logic            beat;
    logic            last_entry;

    // Accept decode and the close decision, using the post-write entry count
    always_comb begin
        accept_ok   = (state == FILL) && (count < CW'(MAX_BATCH)) && !carry_valid;
        is_dup      = 1'b0;
        for (int i = 0; i < MAX_BATCH; i++) begin
            if ((CW'(i) < count) && (entries[i] == owner_programID)) begin
                is_dup = 1'b1;
            end
        end
        do_write    = insertion_ready && accept_ok && !is_dup;
        do_park     = insertion_ready && accept_ok && is_dup;
        count_post  = count + CW'(do_write);
        timed_out   = (count != '0) && (timer == TW'(TIMEOUT - 1));
        close_batch = (state == FILL) &&
                      ((count_post == CW'(MAX_BATCH)) || do_park || timed_out ||
                       (flush && (count_post != '0)));
        last_entry  = (CW'(rd_idx) == count - CW'(1));
        beat        = (state == DRAIN) && out_ready;
    end

    // Entry storage: append on accept, reload slot 0 from carry when a drain ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_write) begin
                entries[count[IW-1:0]] <= owner_programID;
            end else if (beat && last_entry && carry_valid) begin
                entries[0] <= carry_id;
            end
        end
    end

    // Fill/drain state machine with registered feedback pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FILL;
            count          <= '0;
            timer          <= '0;
            rd_idx         <= '0;
            carry_id       <= '0;
            carry_valid    <= 1'b0;
            accepted_id    <= '0;
            accepted_valid <= 1'b0;
            conflict       <= 1'b0;
            drop           <= 1'b0;
            drop_count     <= '0;
        end else begin
            accepted_valid <= 1'b0;
            conflict       <= 1'b0;
            drop           <= 1'b0;
            if (insertion_ready && !accept_ok) begin
                drop <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            case (state)
                FILL: begin
                    if (do_write) begin
                        accepted_id    <= owner_programID;
                        accepted_valid <= 1'b1;
                    end
                    if (do_park) begin
                        carry_id    <= owner_programID;
                        carry_valid <= 1'b1;
                        conflict    <= 1'b1;
                    end
                    // Timer measures the age of the oldest entry in the batch
                    if (count == '0) begin
                        if (do_write) begin
                            timer <= '0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                    count <= count_post;
                    if (close_batch) begin
                        state  <= DRAIN;
                        rd_idx <= '0;
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        if (last_entry) begin
                            state  <= FILL;
                            rd_idx <= '0;
                            timer  <= '0;
                            if (carry_valid) begin
                                count          <= CW'(1);
                                carry_valid    <= 1'b0;
                                accepted_id    <= carry_id;
                                accepted_valid <= 1'b1;
                            end else begin
                                count <= '0;
                            end
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign pipeline_ready = accept_ok && !rst;
    assign out_valid      = (state == DRAIN);
    assign out_id         = (state == DRAIN) ? entries[rd_idx] : '0;
    assign out_last       = (state == DRAIN) && last_entry;
    assign out_size       = (state == DRAIN) ? count : '0;

endmodule

// File: tb/tb_batch_builder.sv
// tb/tb_batch_builder.sv - directed and randomized checks of batch_builder against a queue model
module tb_batch_builder;

    localparam int MAX     = 8;
    localparam int TIMEOUT = 64;
    localparam int SW      = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          insertion_ready;
    logic [63:0]   owner_programID;
    logic          flush;
    logic          pipeline_ready;
    logic [63:0]   accepted_id;
    logic          accepted_valid;
    logic          conflict;
    logic          drop;
    logic [15:0]   drop_count;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_id;
    logic          out_last;
    logic [SW-1:0] out_size;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the open batch as a queue plus a parked carry ID
    logic [63:0] batch [$];
    bit          m_drain;
    int          rd;
    bit          carry_v;
    logic [63:0] carry;
    int          age;
    bit          e_acc_v;
    logic [63:0] e_acc_id;
    bit          e_conf;
    bit          e_drop;
    logic [15:0] e_drop_cnt;

    batch_builder #(.MAX_BATCH(MAX), .ID_W(64), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .insertion_ready(insertion_ready),
        .owner_programID(owner_programID), .flush(flush),
        .pipeline_ready(pipeline_ready), .accepted_id(accepted_id),
        .accepted_valid(accepted_valid), .conflict(conflict), .drop(drop),
        .drop_count(drop_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_last(out_last), .out_size(out_size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        batch.delete();
        m_drain = 0; rd = 0; carry_v = 0; carry = '0; age = 0;
        e_acc_v = 0; e_acc_id = '0; e_conf = 0; e_drop = 0; e_drop_cnt = '0;
    endtask

    function automatic bit m_ready();
        return !m_drain && (batch.size() < MAX) && !carry_v;
    endfunction

    task automatic check_outputs();
        check("pipeline_ready", 64'(pipeline_ready), 64'(rst ? 1'b0 : m_ready()));
        check("accepted_valid", 64'(accepted_valid), 64'(e_acc_v));
        check("accepted_id", accepted_id, e_acc_id);
        check("conflict", 64'(conflict), 64'(e_conf));
        check("drop", 64'(drop), 64'(e_drop));
        check("drop_count", 64'(drop_count), 64'(e_drop_cnt));
        check("out_valid", 64'(out_valid), 64'(m_drain));
        check("out_id", out_id, m_drain ? batch[rd] : 64'd0);
        check("out_last", 64'(out_last), 64'(m_drain && (rd == batch.size() - 1)));
        check("out_size", 64'(out_size), m_drain ? 64'(batch.size()) : 64'd0);
    endtask

    task automatic model_clk(input bit r, input bit ins, input logic [63:0] id,
                             input bit fl, input bit ordy);
        int sz;
        bit rdy;
        bit parked;
        bit tmo;
        bit dup;
        if (r) begin
            m_reset();
            return;
        end
        sz  = batch.size();
        rdy = m_ready();
        e_acc_v = 0; e_conf = 0; e_drop = 0;
        if (ins && !rdy) begin
            e_drop = 1;
            if (e_drop_cnt != 16'hFFFF) e_drop_cnt++;
        end
        if (!m_drain) begin
            parked = 0;
            tmo    = (sz > 0) && (age == TIMEOUT - 1);
            if (ins && rdy) begin
                dup = 0;
                foreach (batch[i]) if (batch[i] == id) dup = 1;
                if (dup) begin
                    carry = id; carry_v = 1; e_conf = 1; parked = 1;
                end else begin
                    batch.push_back(id); e_acc_v = 1; e_acc_id = id;
                end
            end
            if (sz == 0 && batch.size() == 1) age = 0;
            else if (sz > 0) age++;
            if (batch.size() == MAX || parked || tmo || (fl && batch.size() > 0)) begin
                m_drain = 1; rd = 0;
            end
        end else if (ordy) begin
            if (rd == batch.size() - 1) begin
                batch.delete(); m_drain = 0; rd = 0; age = 0;
                if (carry_v) begin
                    batch.push_back(carry); carry_v = 0; e_acc_v = 1; e_acc_id = carry;
                end
            end else begin
                rd++;
            end
        end
    endtask

    task automatic step(input bit r, input bit ins, input logic [63:0] id,
                        input bit fl, input bit ordy);
        rst = r; insertion_ready = ins; owner_programID = id; flush = fl; out_ready = ordy;
        #1;
        check_outputs();
        @(posedge clk);
        model_clk(r, ins, id, fl, ordy);
        @(negedge clk);
    endtask

    task automatic strobe(input logic [63:0] id);
        step(0, 1, id, 0, 0);
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 64'd0, 0, ordy);
    endtask

    initial begin
        int acc;
        int cyc;
        bit rr, ins, fl, ordy;
        logic [63:0] id;

        rst = 1; insertion_ready = 0; owner_programID = '0; flush = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();
        check("rst_pipeline_ready", 64'(pipeline_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_accepted_id", accepted_id, 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);
        check("rst_out_size", 64'(out_size), 64'd0);

        // Full batch of IDs 1..8, strobed every other cycle
        step(1, 0, 0, 0, 0);
        acc = 0;
        for (int i = 1; i <= MAX; i++) begin
            strobe(64'(i));
            if (accepted_valid) acc++;
            if (i < MAX) idle(0);
        end
        check("full_ready_low", 64'(pipeline_ready), 64'd0);
        check("full_acc_count", 64'(acc), 64'd8);
        for (int i = 1; i <= MAX; i++) begin
            check("full_beat_id", out_id, 64'(i));
            check("full_beat_last", 64'(out_last), 64'(i == MAX));
            check("full_beat_size", 64'(out_size), 64'd8);
            idle(1);
        end
        check("full_ready_back", 64'(pipeline_ready), 64'd1);

        // Conflict on repeated ID 5 parks it as the carry
        step(1, 0, 0, 0, 0);
        strobe(64'd5); strobe(64'd6); strobe(64'd5);
        check("conf_pulse", 64'(conflict), 64'd1);
        check("conf_size", 64'(out_size), 64'd2);
        check("conf_beat0", out_id, 64'd5);
        idle(1);
        check("conf_beat1", out_id, 64'd6);
        check("conf_last", 64'(out_last), 64'd1);
        idle(1);
        check("carry_acc_valid", 64'(accepted_valid), 64'd1);
        check("carry_acc_id", accepted_id, 64'd5);
        step(0, 0, 0, 1, 0);
        check("carry_size", 64'(out_size), 64'd1);
        check("carry_id", out_id, 64'd5);
        idle(1);

        // Lone entry closes on timeout
        step(1, 0, 0, 0, 0);
        strobe(64'hA);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            idle(0);
            cyc++;
        end
        check("timeout_latency", 64'(cyc), 64'd65);
        check("timeout_last", 64'(out_last), 64'd1);
        check("timeout_size", 64'(out_size), 64'd1);
        check("timeout_id", out_id, 64'hA);
        idle(1);

        // Strobe dropped while drain is stalled
        step(1, 0, 0, 0, 0);
        strobe(64'h11); strobe(64'h22);
        step(0, 0, 0, 1, 0);
        strobe(64'h33);
        check("drop_pulse", 64'(drop), 64'd1);
        check("drop_cnt", 64'(drop_count), 64'd1);
        check("stall_id", out_id, 64'h11);
        idle(0);
        check("stall_id_held", out_id, 64'h11);
        idle(1);
        check("stall_beat1", out_id, 64'h22);
        idle(1);
        check("stall_done", 64'(out_valid), 64'd0);

        // Flush with a same-cycle strobe, then flush on an empty batch
        step(1, 0, 0, 0, 0);
        strobe(64'd1); strobe(64'd2); strobe(64'd3);
        step(0, 1, 64'd4, 1, 0);
        check("flush_size", 64'(out_size), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check("flush_beat", out_id, 64'(i));
            idle(1);
        end
        step(0, 0, 0, 1, 0);
        check("flush_empty_valid", 64'(out_valid), 64'd0);
        check("flush_empty_ready", 64'(pipeline_ready), 64'd1);
        strobe(64'd9);
        step(0, 0, 0, 1, 0);
        check("flush_after_size", 64'(out_size), 64'd1);
        idle(1);

        // Reset on the second beat of a four-entry drain
        step(1, 0, 0, 0, 0);
        strobe(64'hA1); strobe(64'hA2); strobe(64'hA3); strobe(64'hA4);
        step(0, 0, 0, 1, 0);
        idle(1);
        check("rstd_beat2", out_id, 64'hA2);
        step(1, 0, 0, 0, 1);
        check("rstd_out_valid", 64'(out_valid), 64'd0);
        check("rstd_ready_low", 64'(pipeline_ready), 64'd0);
        rst = 0;
        #1;
        check("rstd_ready_back", 64'(pipeline_ready), 64'd1);
        step(0, 0, 0, 1, 0);
        check("rstd_count0", 64'(out_valid), 64'd0);

        // Randomized traffic with small ID pool to provoke conflicts
        for (int n = 0; n < 4000; n++) begin
            rr   = ($urandom % 600) == 0;
            ins  = ($urandom % 3) != 0;
            fl   = ($urandom % 20) == 0;
            ordy = ($urandom % 4) != 0;
            if (($urandom % 8) == 0) id = {$urandom, $urandom};
            else id = 64'($urandom_range(1, 10));
            step(rr, ins, id, fl, ordy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
